result_stage: RTL and testbench
===============================

RESULT_STAGE -- requirements
Module: result_stage

Interface
REQ-001 Parameter: WIDTH, 16, data width of the bitwise result word (AND16 output).
REQ-002 CLK  input  1  single clock, all state on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 IN_VALID  input  1  upstream result word valid.
REQ-005 IN_DATA  input  WIDTH  result word from the AND16 stage.
REQ-006 IN_READY  output  1  stage can accept a word this cycle.
REQ-007 OUT_VALID  output  1  head word valid.
REQ-008 OUT_DATA  output  WIDTH  head word.
REQ-009 OUT_ZR  output  1  head word equals zero.
REQ-010 OUT_NG  output  1  head word MSB set.
REQ-011 OUT_READY  input  1  downstream accepts head word.
REQ-012 OCCUPANCY  output  2  words held (0..2).

Function
REQ-013 The block SHALL be a 2-entry registered skid buffer; transfer in = IN_VALID&IN_READY, transfer out = OUT_VALID&OUT_READY, both on CLK rising edge.
REQ-014 States SHALL be EMPTY, ONE, FULL; OCCUPANCY SHALL equal 0/1/2 respectively.
REQ-015 EMPTY: in -> ONE; no in -> EMPTY.
REQ-016 ONE: in without out -> FULL; out without in -> EMPTY; in and out together -> ONE with new word as head; neither -> ONE.
REQ-017 FULL: out -> ONE with second word promoted to head; no out -> FULL; IN_VALID ignored.
REQ-018 IN_READY SHALL be registered and deasserted only in FULL (no combinational path OUT_READY -> IN_READY).
REQ-019 OUT_VALID SHALL be 1 in ONE and FULL; OUT_DATA/OUT_ZR/OUT_NG SHALL be driven from registers, never from IN_DATA combinationally.
REQ-020 Latency: a word accepted in EMPTY SHALL appear on OUT_DATA exactly one cycle later.
REQ-021 Order SHALL be preserved; no word dropped or duplicated under any IN_VALID/OUT_READY pattern.
REQ-022 OUT_DATA, OUT_ZR, OUT_NG SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 OUT_ZR SHALL equal (head==0) and OUT_NG SHALL equal head[WIDTH-1], computed at capture time.

Reset
REQ-024 RST_N low SHALL immediately force state EMPTY, OUT_VALID=0, IN_READY=0, OUT_DATA=0, OUT_ZR=0, OUT_NG=0, OCCUPANCY=0.
REQ-025 The first cycle after RST_N release SHALL raise IN_READY=1; no transfer is accepted during that cycle.
REQ-026 Reset mid-operation SHALL discard all held words without emitting them.

Configuration
REQ-027 Macro RESULT_STAGE_FLAGS_EN defined: flag registers built, OUT_ZR/OUT_NG per REQ-023.
REQ-028 Macro RESULT_STAGE_FLAGS_EN undefined: no flag registers; OUT_ZR and OUT_NG SHALL be tied 0; all other behaviour unchanged.

Structure
REQ-029 Shared package SHALL hold the state enum (EMPTY/ONE/FULL), the default WIDTH constant 16, and a result-entry struct (data, zr, ng).
REQ-030 One sub-module result_flags (combinational zr/ng from a WIDTH word) SHALL be instantiated once on the capture path, compiled only under RESULT_STAGE_FLAGS_EN.

Verification
REQ-031 Reset, single word 16'h8000, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=8000, NG=1, ZR=0; then EMPTY.
REQ-032 OUT_READY=0, push 16'h0000 then 16'h1234 -> OCCUPANCY=2, IN_READY=0, head 0000 with ZR=1; third push 16'hFFFF not accepted.
REQ-033 From FULL, OUT_READY=1 two cycles -> outputs 0000 then 1234 in order, IN_READY re-asserts after first pop.
REQ-034 ONE state, simultaneous push 16'h00FF and pop -> OCCUPANCY stays 1, head becomes 00FF next cycle.
REQ-035 Random IN_VALID/OUT_READY over 1000 words with scoreboard -> zero loss, zero duplication, order preserved, hold-stable rule never violated.
REQ-036 RST_N pulsed low while FULL -> outputs zero asynchronously, held words never emitted; build without RESULT_STAGE_FLAGS_EN -> ZR/NG constant 0.

Source files
------------

// File: rtl/result_stage_pkg.sv
// Shared types and constants for the result_stage skid buffer.
// Holds the state enum, default data width and the result-entry record.
package result_stage_pkg;

  localparam int RESULT_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [RESULT_WIDTH-1:0] data;
    logic                    zr;
    logic                    ng;
  } result_entry_t;

  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/result_flags.sv
// Combinational zero/negative flags of a result word, used on the capture path.
// Only compiled when RESULT_STAGE_FLAGS_EN is defined.
`ifdef RESULT_STAGE_FLAGS_EN
module result_flags
  import result_stage_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             zr,
  output logic             ng
);

  assign zr = (data == '0);
  assign ng = data[WIDTH-1];

endmodule
`endif

// File: rtl/result_stage.sv
// Two-entry registered skid buffer for AND16 result words with optional ZR/NG flags.
// Define RESULT_STAGE_FLAGS_EN to build the flag registers; otherwise out_zr/out_ng are tied 0.
//
// state | meaning
// EMPTY | no word held, out_valid low
// ONE   | head word held, in_ready high
// FULL  | head and second word held, in_ready low
module result_stage
  import result_stage_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             push, pop;
  logic             load_head, head_from_tail, load_tail;

  assign push      = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = head_q;
  assign occupancy = state_occupancy(state_q);

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a pure function of the registered next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_head) head_q <= head_from_tail ? tail_q : in_data;
      if (load_tail) tail_q <= in_data;
    end
  end

`ifdef RESULT_STAGE_FLAGS_EN
  logic cap_zr, cap_ng;
  logic head_zr_q, head_ng_q, tail_zr_q, tail_ng_q;

  result_flags #(.WIDTH(WIDTH)) u_flags (
    .data (in_data),
    .zr   (cap_zr),
    .ng   (cap_ng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_zr_q <= 1'b0;
      head_ng_q <= 1'b0;
      tail_zr_q <= 1'b0;
      tail_ng_q <= 1'b0;
    end else begin
      if (load_head) begin
        head_zr_q <= head_from_tail ? tail_zr_q : cap_zr;
        head_ng_q <= head_from_tail ? tail_ng_q : cap_ng;
      end
      if (load_tail) begin
        tail_zr_q <= cap_zr;
        tail_ng_q <= cap_ng;
      end
    end
  end

  assign out_zr = head_zr_q;
  assign out_ng = head_ng_q;
`else
  assign out_zr = 1'b0;
  assign out_ng = 1'b0;
`endif

endmodule

// File: tb/tb_result_stage.sv
// Self-checking bench for result_stage: directed scenarios plus a randomized
// run against a queue model of the two-entry buffer.
module tb_result_stage;
  import result_stage_pkg::*;

  localparam int W = RESULT_WIDTH;
  localparam int NWORDS = 1000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_zr;
  logic         out_ng;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks;
  int passed;

  result_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_zr    (out_zr),
    .out_ng    (out_ng),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_zr(input logic [W-1:0] d);
`ifdef RESULT_STAGE_FLAGS_EN
    return (d == '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ng(input logic [W-1:0] d);
`ifdef RESULT_STAGE_FLAGS_EN
    return d[W-1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 16'hABCD;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else passed++;
    checks++; if (out_zr !== 1'b0 || out_ng !== 1'b0) $display("FAIL reset_flags: got zr=%b ng=%b expected 0 0", out_zr, out_ng); else passed++;
    checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL release_in_ready: got %b expected 0", in_ready); else passed++;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL first_cycle_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL first_cycle_no_accept: got occ=%0d valid=%b expected 0 0", occupancy, out_valid); else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
    checks++; if (out_data !== 16'h8000) $display("FAIL single_data: got %h expected 8000", out_data); else passed++;
    checks++; if (out_ng !== exp_ng(16'h8000)) $display("FAIL single_ng: got %b expected %b", out_ng, exp_ng(16'h8000)); else passed++;
    checks++; if (out_zr !== exp_zr(16'h8000)) $display("FAIL single_zr: got %b expected %b", out_zr, exp_zr(16'h8000)); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL single_empty: got valid=%b occ=%0d expected 0 0", out_valid, occupancy); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0000;
    @(negedge clk);
    in_data = 16'h1234;
    @(negedge clk);
    checks++; if (occupancy !== 2'd2) $display("FAIL fill_occupancy: got %0d expected 2", occupancy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else passed++;
    checks++; if (out_data !== 16'h0000) $display("FAIL fill_head: got %h expected 0000", out_data); else passed++;
    checks++; if (out_zr !== exp_zr(16'h0000)) $display("FAIL fill_zr: got %b expected %b", out_zr, exp_zr(16'h0000)); else passed++;
    in_data = 16'hFFFF;
    @(negedge clk);
    checks++; if (occupancy !== 2'd2 || out_data !== 16'h0000) $display("FAIL fill_third_rejected: got occ=%0d head=%h expected 2 0000", occupancy, out_data); else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    checks++; if (out_data !== 16'h0000 || out_valid !== 1'b1) $display("FAIL drain_first: got %h valid=%b expected 0000 1", out_data, out_valid); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 16'h1234 || out_valid !== 1'b1) $display("FAIL drain_second: got %h valid=%b expected 1234 1", out_data, out_valid); else passed++;
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) $display("FAIL drain_ready: got ready=%b occ=%0d expected 1 1", in_ready, occupancy); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL drain_empty: got valid=%b occ=%0d expected 0 0", out_valid, occupancy); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_simul();
    in_valid = 1'b1;
    in_data  = 16'h1111;
    @(negedge clk);
    in_data   = 16'h00FF;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd1) $display("FAIL simul_occupancy: got %0d expected 1", occupancy); else passed++;
    checks++; if (out_data !== 16'h00FF) $display("FAIL simul_head: got %h expected 00ff", out_data); else passed++;
    checks++; if (out_zr !== exp_zr(16'h00FF) || out_ng !== exp_ng(16'h00FF)) $display("FAIL simul_flags: got zr=%b ng=%b expected %b %b", out_zr, out_ng, exp_zr(16'h00FF), exp_ng(16'h00FF)); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL simul_drain: got valid=%b expected 0", out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    int           sent;
    int           received;
    int           cycle;
    bit           push;
    bit           pop;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    sent       = 0;
    received   = 0;
    cycle      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (received < NWORDS && cycle < 20000) begin
      checks++; if (out_valid !== (q.size() > 0)) $display("FAIL rand_valid: cycle %0d got %b expected %b", cycle, out_valid, q.size() > 0); else passed++;
      checks++; if (occupancy !== 2'(q.size())) $display("FAIL rand_occupancy: cycle %0d got %0d expected %0d", cycle, occupancy, q.size()); else passed++;
      checks++; if (in_ready !== (q.size() < 2)) $display("FAIL rand_in_ready: cycle %0d got %b expected %b", cycle, in_ready, q.size() < 2); else passed++;
      if (q.size() > 0) begin
        checks++; if (out_data !== q[0]) $display("FAIL rand_data: cycle %0d got %h expected %h", cycle, out_data, q[0]); else passed++;
        checks++; if (out_zr !== exp_zr(q[0]) || out_ng !== exp_ng(q[0])) $display("FAIL rand_flags: cycle %0d got zr=%b ng=%b expected %b %b", cycle, out_zr, out_ng, exp_zr(q[0]), exp_ng(q[0])); else passed++;
      end
      if (prev_stall) begin
        checks++; if (out_data !== prev_data) $display("FAIL rand_hold: cycle %0d got %h expected %h", cycle, out_data, prev_data); else passed++;
      end
      in_valid = (sent < NWORDS) && ($urandom_range(0, 3) != 0);
      in_data  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ((cycle / 300) % 2 == 0) out_ready = ($urandom_range(0, 3) == 0);
      else                        out_ready = ($urandom_range(0, 3) != 0);
      push       = in_valid && (q.size() < 2);
      pop        = (q.size() > 0) && out_ready;
      prev_stall = (q.size() > 0) && !out_ready;
      prev_data  = (q.size() > 0) ? q[0] : '0;
      @(posedge clk);
      if (pop) begin
        void'(q.pop_front());
        received++;
      end
      if (push) begin
        q.push_back(in_data);
        sent++;
      end
      cycle++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (received != NWORDS || sent != NWORDS) $display("FAIL rand_budget: got sent=%0d received=%0d expected %0d each", sent, received, NWORDS); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    @(negedge clk);
    in_data = 16'h8001;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) $display("FAIL mid_full: got %0d expected 2", occupancy); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) $display("FAIL mid_async_ctrl: got valid=%b occ=%0d ready=%b expected 0 0 0", out_valid, occupancy, in_ready); else passed++;
    checks++; if (out_data !== '0 || out_zr !== 1'b0 || out_ng !== 1'b0) $display("FAIL mid_async_data: got %h zr=%b ng=%b expected 0000 0 0", out_data, out_zr, out_ng); else passed++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL mid_no_emit: cycle %0d got valid=%b data=%h expected 0", i, out_valid, out_data); else passed++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_simul();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
